lcd_spi_tx: RTL and testbench

- Byte-level SPI transmitter for the PCD8544 (Nokia 5110) LCD; sits directly downstream of the display configuration/drawing controller and drives the LCD pins.
- Controller presents one byte plus a command/data flag and holds start high; block serialises MSB-first (SPI mode 0), pulses avail once per finished byte, then loads the next byte while start stays high.
- Also generates the LCD hardware reset pulse after system reset.

---
 rtl/lcd_spi_tx.sv | 160 ++++++++++++++++
 tb/tb_lcd_spi_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_tx.sv
// Byte-wide SPI mode-0 transmitter that drives a PCD8544 (Nokia 5110) LCD, MSB first.
// Define LCD_HW_RESET_EN to add the LCD hardware reset pulse (rst low, then a settle wait) after reset.
module lcd_spi_tx #(
  parameter int RST_LOW_CYCLES  = 500,
  parameter int RST_WAIT_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        start,
  input  logic [15:0] div_factor,
  input  logic        command,
  output logic        mosi,
  output logic        sclk,
  output logic        sce,
  output logic        dc,
  output logic        rst,
  output logic        busy,
  output logic        avail
);

  typedef enum logic [2:0] {
    HWRST_LOW,
    HWRST_WAIT,
    IDLE,
    SHIFT,
    DONE,
    GAP
  } state_t;

`ifdef LCD_HW_RESET_EN
  localparam state_t RESET_STATE = HWRST_LOW;
  localparam logic   RESET_BUSY  = 1'b1;
  localparam logic   RESET_RST   = 1'b0;
  localparam int     RST_MAX     = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
  localparam int     RCW         = (RST_MAX > 1) ? $clog2(RST_MAX) : 1;
  logic [RCW-1:0] rst_cnt_reg;
`else
  localparam state_t RESET_STATE = IDLE;
  localparam logic   RESET_BUSY  = 1'b0;
  localparam logic   RESET_RST   = 1'b1;
`endif

  // Both counters compare against N-1, so a zero cycle count is meaningless.
  if (RST_LOW_CYCLES < 1 || RST_WAIT_CYCLES < 1) begin : g_param_check
    $error("lcd_spi_tx: reset cycle counts must be at least 1");
  end

  state_t      state_reg;
  logic [6:0]  shift_reg;
  logic [15:0] div_cnt_reg;
  logic [15:0] half_reg;
  logic [3:0]  half_cnt_reg;
  logic        mosi_reg;
  logic        sclk_reg;
  logic        sce_reg;
  logic        dc_reg;
  logic        rst_reg;
  logic        busy_reg;
  logic        avail_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RESET_STATE;
      shift_reg    <= '0;
      div_cnt_reg  <= '0;
      half_reg     <= 16'd1;
      half_cnt_reg <= '0;
      mosi_reg     <= 1'b0;
      sclk_reg     <= 1'b0;
      sce_reg      <= 1'b1;
      dc_reg       <= 1'b0;
      rst_reg      <= RESET_RST;
      busy_reg     <= RESET_BUSY;
      avail_reg    <= 1'b0;
`ifdef LCD_HW_RESET_EN
      rst_cnt_reg  <= '0;
`endif
    end else begin
      avail_reg <= 1'b0;
      case (state_reg)
`ifdef LCD_HW_RESET_EN
        HWRST_LOW: begin
          if (rst_cnt_reg == RCW'(RST_LOW_CYCLES - 1)) begin
            rst_cnt_reg <= '0;
            rst_reg     <= 1'b1;
            state_reg   <= HWRST_WAIT;
          end else begin
            rst_cnt_reg <= rst_cnt_reg + 1'b1;
          end
        end
        HWRST_WAIT: begin
          if (rst_cnt_reg == RCW'(RST_WAIT_CYCLES - 1)) begin
            rst_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            rst_cnt_reg <= rst_cnt_reg + 1'b1;
          end
        end
`endif
        IDLE: begin
          if (start) begin
            shift_reg    <= data_in[6:0];
            mosi_reg     <= data_in[7];
            dc_reg       <= command;
            half_reg     <= (div_factor == 16'd0) ? 16'd1 : div_factor;
            div_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            sclk_reg     <= 1'b0;
            sce_reg      <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_cnt_reg == half_reg - 16'd1) begin
            div_cnt_reg  <= '0;
            half_cnt_reg <= half_cnt_reg + 1'b1;
            if (!sclk_reg) begin
              sclk_reg <= 1'b1;
            end else if (half_cnt_reg == 4'd15) begin
              // Sixteenth half-period: last falling edge closes the byte.
              sclk_reg  <= 1'b0;
              sce_reg   <= 1'b1;
              avail_reg <= 1'b1;
              state_reg <= DONE;
            end else begin
              // Falling edge: present the next bit for a full low phase.
              sclk_reg  <= 1'b0;
              mosi_reg  <= shift_reg[6];
              shift_reg <= {shift_reg[5:0], 1'b0};
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= GAP;
        end
        GAP: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= RESET_STATE;
        end
      endcase
    end
  end

  assign mosi  = mosi_reg;
  assign sclk  = sclk_reg;
  assign sce   = sce_reg;
  assign dc    = dc_reg;
  assign rst   = rst_reg;
  assign busy  = busy_reg;
  assign avail = avail_reg;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Directed, table-driven bench for lcd_spi_tx; outputs are sampled on the falling clock edge.
// Runs with the LCD hardware reset sequence either enabled or disabled (LCD_HW_RESET_EN).
module tb_lcd_spi_tx;

  localparam int LOWC  = 4;
  localparam int WAITC = 3;
`ifdef LCD_HW_RESET_EN
  localparam bit HW = 1'b1;
`else
  localparam bit HW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        start = 1'b0;
  logic [15:0] div_factor = 16'd1;
  logic        command = 1'b0;
  logic        mosi, sclk, sce, dc, rst, busy, avail;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_spi_tx #(.RST_LOW_CYCLES(LOWC), .RST_WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .start(start),
    .div_factor(div_factor), .command(command), .mosi(mosi), .sclk(sclk),
    .sce(sce), .dc(dc), .rst(rst), .busy(busy), .avail(avail)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        c;
    logic [15:0] div;
    int          h;
  } vec_t;

  // Single pulsed byte: start high for one edge only, then watch until IDLE.
  task automatic xfer(input vec_t v);
    logic [7:0] bits;
    logic       dc_seen, prev_sclk;
    int first_low, n_low, rises, bad_period, avail_at, n_avail, prev_rise;
    bits = 8'h00; dc_seen = 1'bx; prev_sclk = 1'b0;
    first_low = -1; n_low = 0; rises = 0; bad_period = 0;
    avail_at = -1; n_avail = 0; prev_rise = -1;
    data_in = v.d; command = v.c; div_factor = v.div; start = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (!sce) begin
        n_low++;
        if (first_low < 0) first_low = k;
        dc_seen = dc;
      end
      if (sclk && !prev_sclk) begin
        bits = {bits[6:0], mosi};
        rises++;
        if (prev_rise >= 0 && (k - prev_rise) != 2 * v.h) bad_period++;
        prev_rise = k;
      end
      prev_sclk = sclk;
      if (avail) begin
        n_avail++;
        if (avail_at < 0) avail_at = k;
      end
      if (avail_at >= 0 && k >= avail_at + 3) break;
    end
    $display("xfer data=%02h cmd=%0b div=%0d: bits=%02h sce_low=%0d rises=%0d avail_at=%0d",
             v.d, v.c, v.div, bits, n_low, rises, avail_at);
    check("xfer_bits", bits, v.d);
    check("xfer_dc", dc_seen, v.c);
    check("xfer_first_sce_low", first_low, 1);
    check("xfer_sce_low_len", n_low, 16 * v.h);
    check("xfer_rises", rises, 8);
    check("xfer_sclk_period", bad_period, 0);
    check("xfer_avail_cycle", avail_at, 16 * v.h + 1);
    check("xfer_avail_count", n_avail, 1);
    check("xfer_idle_busy", busy, 1'b0);
    check("xfer_idle_sce", sce, 1'b1);
    check("xfer_dc_hold", dc, v.c);
  endtask

  // Reset then observe the hardware reset sequence; optionally a byte (0x5A) queued with start high.
  task automatic reset_seq(input bit with_start);
    logic [7:0] bits;
    logic       prev_sclk;
    int n_rst_low, rst_rise, busy_fall, first_sce, early_avail, avail_at, bound;
    bits = 8'h00; prev_sclk = 1'b0;
    n_rst_low = 0; rst_rise = -1; busy_fall = -1; first_sce = -1;
    early_avail = 0; avail_at = -1;
    bound = with_start ? 120 : 40;
    reset = 1'b1; data_in = 8'h5A; command = 1'b1; div_factor = 16'd1; start = with_start;
    repeat (3) @(negedge clk);
    check("rstval_sce", sce, 1'b1);
    check("rstval_sclk", sclk, 1'b0);
    check("rstval_mosi", mosi, 1'b0);
    check("rstval_dc", dc, 1'b0);
    check("rstval_avail", avail, 1'b0);
    check("rstval_busy", busy, HW);
    check("rstval_rst", rst, !HW);
    reset = 1'b0;
    for (int k = 0; k <= bound; k++) begin
      if (k > 0) @(negedge clk);
      if (!rst) n_rst_low++;
      if (rst && rst_rise < 0) rst_rise = k;
      if (!busy && busy_fall < 0) busy_fall = k;
      if (avail && first_sce < 0) early_avail++;
      if (!sce && first_sce < 0) begin
        first_sce = k;
        start = 1'b0;
      end
      if (sclk && !prev_sclk) bits = {bits[6:0], mosi};
      prev_sclk = sclk;
      if (avail && avail_at < 0) avail_at = k;
      if (avail_at >= 0 && k >= avail_at + 3) break;
    end
    $display("reset_seq start=%0b: rst_low=%0d rst_rise=%0d busy_fall=%0d first_sce=%0d",
             with_start, n_rst_low, rst_rise, busy_fall, first_sce);
    check("hwrst_low_len", n_rst_low, HW ? LOWC : 0);
    check("hwrst_rise", rst_rise, HW ? LOWC : 0);
    check("hwrst_busy_fall", busy_fall, HW ? LOWC + WAITC : 0);
    check("hwrst_early_avail", early_avail, 0);
    if (with_start) begin
      check("hwrst_first_sce", first_sce, HW ? LOWC + WAITC + 1 : 1);
      check("hwrst_first_byte", bits, 8'h5A);
      check("hwrst_first_avail", avail_at, (HW ? LOWC + WAITC + 1 : 1) + 16);
    end else begin
      check("hwrst_no_load", first_sce, -1);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [7:0] sbytes[4];
    logic       scmds[4];
    logic [7:0] got[4];
    logic       gotdc[4];
    vec_t       rv;

    vecs[0] = '{d: 8'h21, c: 1'b0, div: 16'd2, h: 2};
    vecs[1] = '{d: 8'hA5, c: 1'b1, div: 16'd0, h: 1};
    vecs[2] = '{d: 8'h3C, c: 1'b0, div: 16'd1, h: 1};
    vecs[3] = '{d: 8'h96, c: 1'b1, div: 16'd3, h: 3};
    vecs[4] = '{d: 8'h00, c: 1'b0, div: 16'd1, h: 1};
    vecs[5] = '{d: 8'hFF, c: 1'b1, div: 16'd2, h: 2};
    sbytes = '{8'h21, 8'h90, 8'h20, 8'h0C};
    scmds  = '{1'b0, 1'b0, 1'b1, 1'b1};

    @(negedge clk);
    reset_seq(1'b1);

    for (int i = 0; i < 6; i++) xfer(vecs[i]);

    // Streaming with start held; the next byte is presented on each avail.
    begin
      int idx, nb, rc, high_run, max_av_run, av_run, n_av, gap_checks, k;
      logic prev_sclk, seen_low;
      logic [7:0] cur;
      idx = 0; nb = 0; rc = 0; high_run = 0; max_av_run = 0; av_run = 0; n_av = 0;
      gap_checks = 0; prev_sclk = 1'b0; seen_low = 1'b0; cur = 8'h00;
      got = '{8'h00, 8'h00, 8'h00, 8'h00};
      gotdc = '{1'b0, 1'b0, 1'b0, 1'b0};
      data_in = sbytes[0]; command = scmds[0]; div_factor = 16'd1; start = 1'b1;
      for (k = 1; k <= 400; k++) begin
        @(negedge clk);
        if (sclk && !prev_sclk) begin
          cur = {cur[6:0], mosi};
          rc++;
          if (rc == 8 && nb < 4) begin
            got[nb] = cur; gotdc[nb] = dc; nb++; rc = 0;
          end
        end
        prev_sclk = sclk;
        if (!sce) begin
          if (seen_low && high_run > 0) begin
            check("stream_sce_gap", high_run, 3);
            gap_checks++;
          end
          high_run = 0;
          seen_low = 1'b1;
        end else begin
          high_run++;
        end
        if (avail) begin
          av_run++;
          if (av_run > max_av_run) max_av_run = av_run;
          n_av++;
          idx++;
          if (idx < 4) begin
            data_in = sbytes[idx]; command = scmds[idx];
          end else begin
            start = 1'b0;
          end
        end else begin
          av_run = 0;
        end
        if (n_av >= 4 && high_run >= 8) break;
      end
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        $display("stream byte %0d: got=%02h dc=%0b", i, got[i], gotdc[i]);
        check("stream_byte", got[i], sbytes[i]);
        check("stream_dc", gotdc[i], scmds[i]);
      end
      check("stream_avail_count", n_av, 4);
      check("stream_gap_count", gap_checks, 3);
      check("stream_avail_width", max_av_run, 1);
      check("stream_idle_busy", busy, 1'b0);
    end

    // Reset during bit 4 of 0xFF at div_factor=3: abort, no avail for the dropped byte.
    begin
      int rises, k;
      logic prev_sclk;
      rises = 0; prev_sclk = 1'b0;
      data_in = 8'hFF; command = 1'b1; div_factor = 16'd3; start = 1'b1;
      for (k = 1; k <= 200; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (sclk && !prev_sclk) rises++;
        prev_sclk = sclk;
        if (rises == 4) break;
      end
      check("abort_reached_bit4", rises, 4);
      reset = 1'b1;
      @(negedge clk);
      $display("abort reset: sce=%0b sclk=%0b avail=%0b busy=%0b rst=%0b", sce, sclk, avail, busy, rst);
      check("abort_sce", sce, 1'b1);
      check("abort_sclk", sclk, 1'b0);
      check("abort_avail", avail, 1'b0);
      check("abort_busy", busy, HW);
      check("abort_rst", rst, !HW);
      reset_seq(1'b0);
      check("abort_idle_sce", sce, 1'b1);
    end

    rv = '{d: 8'hC3, c: 1'b1, div: 16'd1, h: 1};
    xfer(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
